// File: rtl/fp16_pkg.sv
// Shared FP16 types and constants for the adder datapath.
// Holds the packed FP16 word layout and the special encodings.
package fp16_pkg;

  typedef struct packed {
    logic       sign;
    logic [4:0] exp;
    logic [9:0] mant;
  } fp16_t;

  localparam logic [4:0]  FP16_EXP_BIAS = 5'd15;
  localparam logic [4:0]  FP16_EXP_MAX  = 5'd31;
  localparam logic [15:0] FP16_POS_INF  = 16'h7C00;
  localparam logic [15:0] FP16_ZERO     = 16'h0000;

endpackage

// File: rtl/fp_lzd12.sv
// 12-bit leading-one detector: o_cnt = 11 - msb index, o_zero when empty.
// Ports: i_d data in, o_cnt left-shift count, o_zero all-zero flag.
module fp_lzd12 (
  input  logic [11:0] i_d,
  output logic [3:0]  o_cnt,
  output logic        o_zero
);

  // Scan upward so the highest set bit wins.
  always_comb begin
    o_cnt = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (i_d[i]) o_cnt = 4'(11 - i);
    end
  end

  assign o_zero = ~|i_d;

endmodule

// File: rtl/fp16_norm_round.sv
// FP16 normalize/round/pack: S1 normalizes, S2 rounds RNE and packs.
// Ports: clk, rst (sync, high), in_* valid/ready input bundle,
// out_valid/out_ready/out_fp16 result. Define FP16_NORM_EXC_FLAGS_EN
// to add out_flags[2:0] = {overflow, underflow, inexact}.
module fp16_norm_round
  import fp16_pkg::*;
#(
  parameter int FRAC_W = 13,
  parameter int EXP_W  = 5,
  parameter int MANT_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [FRAC_W-1:0] in_frac,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic              in_sticky,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_fp16
`ifdef FP16_NORM_EXC_FLAGS_EN
  ,
  output logic [2:0]        out_flags
`endif
);

  logic [3:0]        w_k;
  logic              w_lz_zero;
  logic              w_zero;
  logic [10:0]       w_n;
  logic signed [6:0] w_e;
  logic              w_st;
  logic              w_s1_adv;

  logic              r_s1_valid;
  logic              r_s1_sign;
  logic              r_s1_zero;
  logic [10:0]       r_s1_n;
  logic signed [6:0] r_s1_e;
  logic              r_s1_st;
  logic              r_s2_valid;
  logic [15:0]       r_out;

  fp_lzd12 u_lzd (
    .i_d    (in_frac[11:0]),
    .o_cnt  (w_k),
    .o_zero (w_lz_zero)
  );

  assign w_zero = w_lz_zero & ~in_frac[12];

  // The leading one (n[11]) is implicit and not stored.
  always_comb begin
    w_n  = 11'(in_frac[11:0] << w_k);
    w_e  = 7'({2'b00, in_exp}) - 7'({3'b000, w_k});
    w_st = in_sticky;
    if (in_frac[12]) begin
      w_n  = in_frac[11:1];
      w_e  = 7'({2'b00, in_exp}) + 7'd1;
      w_st = in_sticky | in_frac[0];
    end
  end

  logic              w_g;
  logic              w_up;
  logic [MANT_W:0]   w_msum;
  logic signed [6:0] w_e2;
  logic              w_flush;
  logic              w_inf;
  fp16_t             w_res;

  assign w_g    = r_s1_n[0];
  assign w_up   = w_g & (r_s1_st | r_s1_n[1]);
  assign w_msum = {1'b0, r_s1_n[10:1]} + 11'(w_up);
  // Mantissa carry wraps to zero and bumps the exponent.
  assign w_e2    = r_s1_e + 7'(w_msum[MANT_W]);
  assign w_flush = (w_e2 <= 7'sd0);
  assign w_inf   = (w_e2 >= $signed({2'b00, FP16_EXP_MAX}));

  always_comb begin
    w_res = {r_s1_sign, w_e2[4:0], w_msum[MANT_W-1:0]};
    if (r_s1_zero)    w_res = FP16_ZERO;
    else if (w_flush) w_res = {r_s1_sign, 15'h0};
    else if (w_inf)   w_res = FP16_POS_INF | {r_s1_sign, 15'h0};
  end

  assign w_s1_adv  = ~r_s2_valid | out_ready;
  assign in_ready  = ~r_s1_valid | w_s1_adv;
  assign out_valid = r_s2_valid;
  assign out_fp16  = r_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_zero  <= 1'b0;
      r_s1_n     <= '0;
      r_s1_e     <= '0;
      r_s1_st    <= 1'b0;
      r_s2_valid <= 1'b0;
      r_out      <= '0;
    end else begin
      if (in_ready) r_s1_valid <= in_valid;
      if (in_valid && in_ready) begin
        r_s1_sign <= in_sign;
        r_s1_zero <= w_zero;
        r_s1_n    <= w_n;
        r_s1_e    <= w_e;
        r_s1_st   <= w_st;
      end
      if (w_s1_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) r_out <= w_res;
      end
    end
  end

`ifdef FP16_NORM_EXC_FLAGS_EN
  logic       w_ovf;
  logic       w_unf;
  logic       w_inx;
  logic [2:0] r_flags;

  assign w_ovf = ~r_s1_zero & ~w_flush & w_inf;
  assign w_unf = ~r_s1_zero & w_flush;
  assign w_inx = w_g | r_s1_st | w_ovf | w_unf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags <= '0;
    end else if (w_s1_adv && r_s1_valid) begin
      r_flags <= {w_ovf, w_unf, w_inx};
    end
  end

  assign out_flags = r_flags;
`endif

endmodule

// File: tb/tb_fp16_norm_round.sv
// Scoreboard bench for fp16_norm_round with a value-level RNE model.
// Directed spec cases, backpressure, mid-flight reset, random traffic.
module tb_fp16_norm_round;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [12:0] in_frac = '0;
  logic [4:0]  in_exp = '0;
  logic        in_sticky = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_fp16;
`ifdef FP16_NORM_EXC_FLAGS_EN
  logic [2:0]  out_flags;
`endif

  fp16_norm_round dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (in_sign),
    .in_frac   (in_frac),
    .in_exp    (in_exp),
    .in_sticky (in_sticky),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_fp16  (out_fp16)
`ifdef FP16_NORM_EXC_FLAGS_EN
    ,
    .out_flags (out_flags)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int rdy_mode = 0;
  logic [15:0] q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Value view: bit 11 of frac has weight 1 at biased exponent e.
  function automatic logic [15:0] ref_model(input logic s,
      input logic [12:0] f, input logic [4:0] e, input logic st);
    int p, sig, rem, half, eb;
    bit up;
    if (f == 13'h0) return 16'h0000;
    p = 0;
    for (int i = 0; i < 13; i++) if (f[i]) p = i;
    eb = int'(e) + p - 11;
    rem = 0;
    half = 0;
    if (p > 10) begin
      sig  = int'(f) >> (p - 10);
      rem  = int'(f) & ((1 << (p - 10)) - 1);
      half = 1 << (p - 11);
    end else begin
      sig = int'(f) << (10 - p);
    end
    up = (rem > half) ||
         (rem == half && rem != 0 && (st || (sig % 2) == 1));
    sig = sig + int'(up);
    if (sig == 2048) begin
      sig = 1024;
      eb = eb + 1;
    end
    if (eb <= 0) return {s, 15'h0};
    if (eb >= 31) return {s, 5'h1F, 10'h0};
    return {s, 5'(eb), 10'(sig)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got %h want none", out_fp16);
      end else begin
        chk("scoreboard", {16'h0, out_fp16}, {16'h0, q.pop_front()});
      end
    end
  end

  // Called just after a rising edge; returns just after the accept edge.
  task automatic send(input logic s, input logic [12:0] f,
                      input logic [4:0] e, input logic st,
                      input logic [15:0] exp_v);
    int n = 0;
    in_valid  = 1'b1;
    in_sign   = s;
    in_frac   = f;
    in_exp    = e;
    in_sticky = st;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(posedge clk);
      #1;
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 want 1");
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      return;
    end
    q.push_back(exp_v);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_r(input logic s, input logic [12:0] f,
                        input logic [4:0] e, input logic st);
    send(s, f, e, st, ref_model(s, f, e, st));
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (q.size() != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL %s: got %0d pending want 0", nm, q.size());
      q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    logic [15:0] e1;
    logic [12:0] rf;
    int w;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_out_fp16", {16'h0, out_fp16}, 32'h0);
    rst = 1'b0;
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    send(1'b0, 13'h1000, 5'd15, 1'b0, 16'h4000);
    @(negedge clk);
    chk("latency_c1", {31'h0, out_valid}, 32'h0);
    @(negedge clk);
    chk("latency_c2", {31'h0, out_valid}, 32'h1);
    @(posedge clk);
    #1;

    c0 = cyc;
    send(1'b1, 13'h0400, 5'd15, 1'b0, 16'hB800);
    send(1'b1, 13'h0000, 5'd9,  1'b0, 16'h0000);
    send(1'b0, 13'h0000, 5'd20, 1'b1, 16'h0000);
    send(1'b0, 13'h0FFF, 5'd15, 1'b0, 16'h4000);
    send(1'b0, 13'h0801, 5'd15, 1'b0, 16'h3C00);
    send(1'b0, 13'h0801, 5'd15, 1'b1, 16'h3C01);
    send(1'b0, 13'h1000, 5'd30, 1'b0, 16'h7C00);
    send(1'b1, 13'h0400, 5'd1,  1'b0, 16'h8000);
    send(1'b0, 13'h1000, 5'd0,  1'b0, 16'h0400);
    send(1'b1, 13'h1FFF, 5'd29, 1'b0, 16'hFC00);
    send(1'b0, 13'h1FFE, 5'd15, 1'b0, 16'h4400);
    send(1'b0, 13'h0003, 5'd20, 1'b0, 16'h2A00);
    chk("back_to_back", cyc - c0, 32'd12);
    drain("drain_directed");

    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    e1 = ref_model(1'b0, 13'h0C00, 5'd10, 1'b0);
    send_r(1'b0, 13'h0C00, 5'd10, 1'b0);
    send_r(1'b1, 13'h0A55, 5'd12, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'h0, in_ready}, 32'h0);
      chk("bp_out_valid", {31'h0, out_valid}, 32'h1);
      chk("bp_hold", {16'h0, out_fp16}, {16'h0, e1});
      @(posedge clk);
      #1;
    end
    rdy_mode = 0;
    send_r(1'b0, 13'h1234, 5'd17, 1'b0);
    send_r(1'b1, 13'h0077, 5'd22, 1'b1);
    drain("drain_bp");

    rdy_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    send_r(1'b0, 13'h0F0F, 5'd14, 1'b0);
    send_r(1'b1, 13'h1111, 5'd16, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    chk("mid_rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("mid_rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("mid_rst_out_fp16", {16'h0, out_fp16}, 32'h0);
    rst = 1'b0;
    rdy_mode = 0;
    send(1'b0, 13'h0400, 5'd15, 1'b0, 16'h3800);
    drain("drain_rst");

    rdy_mode = 1;
    for (int i = 0; i < 400; i++) begin
      w  = $urandom_range(1, 13);
      rf = 13'($urandom & ((32'h1 << w) - 1));
      send_r(1'($urandom), rf, 5'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain("drain_random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp16_norm_round.md
Name: fp16_norm_round

Overview:
- Final stage of the FP16 adder datapath in the systolic-array PE.
- Consumes the sign and 13-bit magnitude produced by the signed-to-unsigned conversion stage, plus the aligned exponent and a sticky bit.
- Normalizes via leading-one detection and shift, rounds to nearest-even, handles overflow and underflow, and packs an IEEE FP16 word.
- 2-stage pipeline with a valid/ready handshake; throughput of one result per cycle.

Parameters:
- FRAC_W, 13, width of the input magnitude. Only the default is supported.
- EXP_W, 5, width of the FP16 biased exponent.
- MANT_W, 10, width of the FP16 stored mantissa.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  stage can accept data.
- in_sign  input  1  sign from the conversion stage.
- in_frac  input  13  magnitude. Bit 12 has weight 2, bit 11 weight 1, bits 10:1 are the fraction, bit 0 is the guard bit.
- in_exp  input  5  biased exponent of the aligned operands.
- in_sticky  input  1  OR of the bits shifted out during alignment.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_fp16  output  16  packed result {sign, exp[4:0], mant[9:0]}.

Behaviour:
- Reset: all pipeline valids, out_valid and out_fp16 go to 0 on the first clk edge with rst=1. rst has priority over every other event, including mid-operation; in-flight data is dropped.
- Handshake:
  - Transfer when valid && ready. S1 advances when !s2_valid || out_ready.
  - in_ready = !s1_valid || s1_advance.
  - Data holds stable while out_valid && !out_ready. No combinational path from in_valid to out_valid.
- Latency: 2 cycles from input transfer to out_valid with out_ready held high. Back-to-back inputs produce back-to-back outputs.
- S1 (normalize):
  - If in_frac==0: flag zero.
  - Else if in_frac[12]=1: n[11:0]=in_frac[12:1], e=in_exp+1, sticky|=in_frac[0].
  - Else: k = 11 − position of the leading one in in_frac[11:0]; n = in_frac[11:0]<<k (zero fill); e = in_exp − k.
  - e is held as a 7-bit signed value.
- S2 (round/pack):
  - G=n[0], L=n[1]. Round up iff G && (sticky || L).
  - m = n[10:1] + roundup. If m overflows 10 bits, set m=0 and e=e+1.
- Exception rules, in priority order:
  - zero flag: 16'h0000 (sign forced to 0).
  - e ≤ 0: flush to signed zero {sign, 15'h0}. No subnormals are produced.
  - e ≥ 31: signed infinity {sign, 5'h1F, 10'h0}.
  - Otherwise {sign, e[4:0], m}.
- Input in_exp==0 with nonzero frac follows the normal e ≤ 0 rule.
- Simultaneous input accept and output drain in the same cycle is legal. Order is strictly preserved.

Optional Feature:
- Macro: FP16_NORM_EXC_FLAGS_EN.
- When defined, adds output port out_flags[2:0] = {overflow, underflow, inexact}, registered alongside out_fp16, reset to 0.
  - overflow: the infinity path was taken.
  - underflow: the flush path was taken on a nonzero value.
  - inexact: G || sticky, or overflow, or underflow.
- When undefined, the port and its logic are absent; datapath results are identical.

Decomposition:
- Shared package fp16_pkg:
  - typedef fp16_t packed struct {sign, exp[4:0], mant[9:0]}.
  - Constants: FP16_EXP_BIAS=15, FP16_EXP_MAX=31, FP16_POS_INF=16'h7C00, FP16_ZERO=16'h0000.
- Sub-module fp_lzd12: combinational 12-bit leading-one detector returning a 4-bit shift count and an all-zero flag. Instantiated in S1.

Test Plan:
- in_frac=13'h1000, exp=15, sign=0 (1.0+1.0) -> out_fp16=16'h4000 two cycles later.
- in_frac=13'h0400, exp=15, sign=1 -> 16'hB800; in_frac=0 with any sign -> 16'h0000.
- Rounding:
  - in_frac=13'h0FFF, exp=15, sticky=0 -> mantissa carry -> 16'h4000.
  - in_frac=13'h0801, sticky=0 -> 16'h3C00 (tie to even).
  - Same input with sticky=1 -> 16'h3C01.
- Exceptions:
  - in_frac=13'h1000, exp=30 -> 16'h7C00 (overflow flag when enabled).
  - in_frac=13'h0400, exp=1, sign=1 -> 16'h8000 (underflow flag when enabled).
- Backpressure: stream 4 values, hold out_ready=0 for 3 cycles -> in_ready drops with 2 results held, out_fp16 stays stable, then all 4 drain in order with none lost or duplicated.
- Reset: assert rst for 1 cycle with both stages full -> next cycle out_valid=0, in_ready=1, out_fp16=0; the following input produces a correct result.
